pn_swap_node: RTL and testbench
===============================

Name: pn_swap_node

Overview:
- Registered 2x2 node for the permutation-network router. One instance per network stage.
- Compares the ages of two incoming flits and picks a winner. The winner is steered to its preferred output; the loser takes the other output.
- Generalises the combinational age arbiter:
  - flit width and time field are parametrised;
  - priority is age-first, with a fairness tie-breaker that toggles automatically;
  - the routing swap decision and its output register are built in;
  - deflections are flagged.

Parameters:
- FLIT_W, 64, flit width in bits.
- TIME_W, 8, width of the age/time field.
- TIME_LSB, 0, bit offset of the time field inside the flit.
- PORT_BIT, 8, flit bit holding the preferred output port (0/1) for this stage.
- MAX_TIME, 2^TIME_W-1, effective time substituted when time field = 0.
- TIE_PERIOD, 4, number of tie events after which the tie-priority port toggles (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  stage advance; 0 = hold all registers.
- mode_ovr  in  1  1 = use mode_val as tie-priority; the auto-toggle counter is frozen.
- mode_val  in  1  forced tie-priority port (0: flit0 wins ties, 1: flit1 wins ties).
- in0_valid  in  1  input 0 flit valid.
- in0_flit  in  FLIT_W  input 0 flit.
- in1_valid  in  1  input 1 flit valid.
- in1_flit  in  FLIT_W  input 1 flit.
- out0_valid  out  1  registered output 0 valid.
- out0_flit  out  FLIT_W  registered output 0 flit.
- out1_valid  out  1  registered output 1 valid.
- out1_flit  out  FLIT_W  registered output 1 flit.
- swap_q  out  1  registered swap decision for the flits now on the outputs.
- defl_q  out  1  registered pulse: the loser did not get its preferred port.
- tie_prio  out  1  current effective tie-priority port.

Behaviour:
- **Reset** (rst_n=0, async): all outputs go to 0, including the internal tie-priority register and the tie counter. Reset applied mid-operation discards in-flight flits.
- **Time extract:**
  - t_i = flit_i[TIME_LSB +: TIME_W].
  - eff_i = MAX_TIME if t_i==0, else t_i (unsigned).
  - Smaller eff_i = older = higher priority.
- **Effective tie port:** tp = mode_ovr ? mode_val : internal tie register. The tie_prio output = tp, combinational.
- **Winner w:**
  - only in0 valid -> 0; only in1 valid -> 1;
  - both valid -> the index with the smaller eff; if eff0==eff1 -> tp;
  - neither valid -> w=0.
- **Swap:**
  - swap = w XOR flit_w[PORT_BIT] when any input is valid.
  - swap = 0 when both inputs are invalid.
- **Defl:** 1 only when both inputs are valid and flit0[PORT_BIT]==flit1[PORT_BIT].
- **Datapath:** data and valid travel together. Swap=1 routes in0->out1 and in1->out0. Invalid flit data passes through unmodified.
- **Latency and hold:**
  - Latency is 1 cycle: outputs, swap_q and defl_q update on the rising edge when en=1.
  - When en=0, all registers hold, including the counter and the tie register.
- **Tie counter (width clog2(TIE_PERIOD)+1):**
  - A tie event is: en=1, mode_ovr=0, both inputs valid, eff0==eff1.
  - On a tie event: if counter==TIE_PERIOD-1, the tie register toggles and the counter clears; otherwise the counter increments.
  - TIE_PERIOD=1 toggles on every tie.
  - Non-tie cycles leave the counter unchanged.
  - Asserting or deasserting mode_ovr does not clear the counter.
- **Boundary cases:**
  - Both times 0 -> both eff=MAX_TIME -> counts as a tie.
  - Time MAX_TIME and time 0 compare equal.
  - Time 1 beats time 0.

Test Plan:
1. Reset check: after rst_n low, all outputs are 0. Then in0 {valid, t=5, port=1} and in1 {valid, t=9, port=1} with en=1 -> next cycle out1 = in0 flit, out0 = in1 flit, swap_q=1, defl_q=1.
2. Single-valid case: only in1 valid, t=3, port=1 -> out1 = in1 flit, out0_valid=0, swap_q=0, defl_q=0. Only in1 valid with port=0 -> swap_q=1.
3. Zero-time case: in0 t=0, in1 t=200, both port=0 -> in1 wins, out0 = in1 flit, swap_q=1, defl_q=1.
4. Tie fairness with TIE_PERIOD=4, mode_ovr=0: drive 4 consecutive ties (t=7/7, both port=0) -> winners are 0,0,0,0 and tie_prio goes to 1 after the 4th. The next 4 ties -> winners are 1,1,1,1, then tie_prio returns to 0.
5. Override: mode_ovr=1, mode_val=1 with ties -> flit1 always wins. Counter frozen: after releasing the override, the prior count resumes (e.g. 2 ties before the override + 2 after -> toggle).
6. Hold: en=0 for 3 cycles while inputs change -> outputs, swap_q and tie_prio stay stable. Assert rst_n=0 mid-hold -> all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pn_swap_node.sv
// pn_swap_node: registered 2x2 permutation-network node; the older flit (smaller
// effective time) takes its preferred port, ties go to an auto-toggling priority port.
module pn_swap_node #(
    parameter int FLIT_W     = 64,
    parameter int TIME_W     = 8,
    parameter int TIME_LSB   = 0,
    parameter int PORT_BIT   = 8,
    parameter int MAX_TIME   = 2**TIME_W - 1,
    parameter int TIE_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode_ovr,
    input  logic              mode_val,
    input  logic              in0_valid,
    input  logic [FLIT_W-1:0] in0_flit,
    input  logic              in1_valid,
    input  logic [FLIT_W-1:0] in1_flit,
    output logic              out0_valid,
    output logic [FLIT_W-1:0] out0_flit,
    output logic              out1_valid,
    output logic [FLIT_W-1:0] out1_flit,
    output logic              swap_q,
    output logic              defl_q,
    output logic              tie_prio
);
    localparam int CNT_W = $clog2(TIE_PERIOD) + 1;
    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIE_PERIOD - 1);

    logic [TIME_W-1:0] t0, t1, eff0, eff1;
    logic [CNT_W-1:0]  cnt;
    logic              tie_q, both, tie, w, pw, swap, defl, tie_ev;

    assign t0       = in0_flit[TIME_LSB +: TIME_W];
    assign t1       = in1_flit[TIME_LSB +: TIME_W];
    // A zero time field means "no age recorded" and ranks as youngest.
    assign eff0     = (t0 == '0) ? MAX_T : t0;
    assign eff1     = (t1 == '0) ? MAX_T : t1;
    assign tie_prio = mode_ovr ? mode_val : tie_q;
    assign both     = in0_valid & in1_valid;
    assign tie      = both & (eff0 == eff1);
    assign w        = both ? (tie ? tie_prio : (eff1 < eff0)) : in1_valid;
    assign pw       = w ? in1_flit[PORT_BIT] : in0_flit[PORT_BIT];
    assign swap     = (in0_valid | in1_valid) & (w ^ pw);
    assign defl     = both & (in0_flit[PORT_BIT] == in1_flit[PORT_BIT]);
    assign tie_ev   = en & ~mode_ovr & tie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid <= 1'b0;
            out0_flit  <= '0;
            out1_valid <= 1'b0;
            out1_flit  <= '0;
            swap_q     <= 1'b0;
            defl_q     <= 1'b0;
            tie_q      <= 1'b0;
            cnt        <= '0;
        end else if (en) begin
            out0_valid <= swap ? in1_valid : in0_valid;
            out0_flit  <= swap ? in1_flit : in0_flit;
            out1_valid <= swap ? in0_valid : in1_valid;
            out1_flit  <= swap ? in0_flit : in1_flit;
            swap_q     <= swap;
            defl_q     <= defl;
            if (tie_ev) begin
                cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                tie_q <= (cnt == CNT_LAST) ? ~tie_q : tie_q;
            end
        end
    end
endmodule

// File: tb/tb_pn_swap_node.sv
// tb_pn_swap_node: table vectors, hand sequences and randomized traffic checked
// against an age/tie-count reference model.
module tb_pn_swap_node;
    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, mode_ovr = 1'b0, mode_val = 1'b0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic [63:0] in0_flit = '0, in1_flit = '0;
    logic        out0_valid, out1_valid, swap_q, defl_q, tie_prio;
    logic [63:0] out0_flit, out1_flit;

    int          total = 0, passed = 0;
    int          ties = 0;
    logic        m_v[2];
    logic [63:0] m_f[2];
    logic        m_swap = 1'b0, m_defl = 1'b0;

    pn_swap_node #(.FLIT_W(64), .TIME_W(8), .TIME_LSB(0), .PORT_BIT(8),
                   .MAX_TIME(255), .TIE_PERIOD(TP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_ovr(mode_ovr), .mode_val(mode_val),
        .in0_valid(in0_valid), .in0_flit(in0_flit), .in1_valid(in1_valid), .in1_flit(in1_flit),
        .out0_valid(out0_valid), .out0_flit(out0_flit), .out1_valid(out1_valid),
        .out1_flit(out1_flit), .swap_q(swap_q), .defl_q(defl_q), .tie_prio(tie_prio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int eff(input logic [63:0] f);
        return (f[7:0] == 8'd0) ? 255 : int'(f[7:0]);
    endfunction

    // Tie priority = parity of the number of completed TIE_PERIOD-sized groups of ties.
    function automatic logic model_tp();
        return mode_ovr ? mode_val : logic'((ties / TP) % 2);
    endfunction

    function automatic logic [63:0] mk(input int t, input logic port);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[7:0] = 8'(t);
        f[8] = port;
        return f;
    endfunction

    task automatic check_all();
        chk("out0_valid", out0_valid, m_v[0]);
        chk("out0_flit", out0_flit, m_f[0]);
        chk("out1_valid", out1_valid, m_v[1]);
        chk("out1_flit", out1_flit, m_f[1]);
        chk("swap_q", swap_q, m_swap);
        chk("defl_q", defl_q, m_defl);
        chk("tie_prio", tie_prio, model_tp());
    endtask

    task automatic model_clear();
        m_v = '{1'b0, 1'b0};
        m_f = '{64'd0, 64'd0};
        m_swap = 1'b0;
        m_defl = 1'b0;
        ties = 0;
    endtask

    // One clock: model the winner steering to its preferred port, then compare.
    task automatic tick();
        logic        v[2];
        logic [63:0] f[2];
        int          w, wp, e0, e1;
        v = '{in0_valid, in1_valid};
        f = '{in0_flit, in1_flit};
        if (en) begin
            e0 = eff(f[0]);
            e1 = eff(f[1]);
            if (v[0] && v[1]) w = (e0 < e1) ? 0 : (e1 < e0) ? 1 : int'(model_tp());
            else w = v[1] ? 1 : 0;
            if (!v[0] && !v[1]) begin
                m_v = v;
                m_f = f;
                m_swap = 1'b0;
            end else begin
                wp = f[w][8] ? 1 : 0;
                m_v[wp] = v[w];
                m_f[wp] = f[w];
                m_v[1-wp] = v[1-w];
                m_f[1-wp] = f[1-w];
                m_swap = (wp != w);
            end
            m_defl = v[0] && v[1] && (f[0][8] == f[1][8]);
            if (!mode_ovr && v[0] && v[1] && e0 == e1) ties++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v0, input int t0, input logic p0,
                         input logic v1, input int t1, input logic p1);
        in0_valid = v0;
        in0_flit = mk(t0, p0);
        in1_valid = v1;
        in1_flit = mk(t1, p1);
    endtask

    typedef struct {
        logic v0; int t0; logic p0;
        logic v1; int t1; logic p1;
        logic e_swap; logic e_defl;
    } vec_t;

    function automatic int rt();
        int k;
        k = $urandom_range(0, 4);
        return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 255 : (k == 3) ? 7 : $urandom_range(0, 255);
    endfunction

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b1, 5,   1'b1, 1'b1, 9,   1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 0,   1'b0, 1'b1, 3,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 0,   1'b0, 1'b1, 3,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 0,   1'b0, 1'b1, 200, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1,   1'b1, 1'b1, 0,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 255, 1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 4,   1'b1, 1'b0, 2,   1'b0, 1'b0, 1'b0};

        model_clear();
        do_reset();
        en = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].t0, vecs[i].p0, vecs[i].v1, vecs[i].t1, vecs[i].p1);
            tick();
            chk($sformatf("vec%0d_swap", i), swap_q, vecs[i].e_swap);
            chk($sformatf("vec%0d_defl", i), defl_q, vecs[i].e_defl);
            chk($sformatf("vec%0d_out0", i), out0_flit, vecs[i].e_swap ? in1_flit : in0_flit);
        end

        // Tie fairness: four ties to port 0, toggle, four ties to port 1, toggle back.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 7, 1'b0, 1'b1, 7, 1'b0);
            tick();
            chk($sformatf("tie%0d_winner", i), swap_q, logic'(i >= 4));
            if (i == 3) chk("tie_prio_after4", tie_prio, 1'b1);
            if (i == 7) chk("tie_prio_after8", tie_prio, 1'b0);
        end

        // Override freezes the counter: 2 ties, 3 overridden, then 2 more toggles.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 7, 1'b0, 1'b1, 7, 1'b0);
            tick();
        end
        mode_ovr = 1'b1;
        mode_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7, 1'b0, 1'b1, 7, 1'b0);
            tick();
            chk($sformatf("ovr%0d_flit1_wins", i), swap_q, 1'b1);
        end
        mode_ovr = 1'b0;
        #1;
        chk("ovr_release_prio", tie_prio, 1'b0);
        drive(1'b1, 7, 1'b0, 1'b1, 7, 1'b0);
        tick();
        chk("resume_tie3_prio", tie_prio, 1'b0);
        drive(1'b1, 7, 1'b0, 1'b1, 7, 1'b0);
        tick();
        chk("resume_tie4_prio", tie_prio, 1'b1);

        // Hold with changing tie inputs, then asynchronous reset mid-hold.
        drive(1'b1, 3, 1'b1, 1'b1, 9, 1'b1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5, 1'b0, 1'b1, 5, 1'b1);
            tick();
            chk($sformatf("hold%0d_swap", i), swap_q, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            mode_ovr = ($urandom_range(0, 7) == 0);
            mode_val = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), rt(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rt(), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
